// File: rtl/glm_collect_pkg.sv
// Shared constants and FSM state type for the GLM S-box layer collector.
package glm_collect_pkg;

    localparam int NIB = 16;  // PRINCE state nibbles
    localparam int DOM = 16;  // d1 domains per 4-bit S-box
    localparam int W   = 4;   // nibble slice width

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/glm_sbox_collect_if.sv
// Bundle of control, domain-term and result signals between the upstream
// domain logic and the collector.
interface glm_sbox_collect_if;
    import glm_collect_pkg::*;

    logic               start;
    logic [DOM*W-1:0]   dom_s;
    logic [DOM*W-1:0]   dom_t;
    logic [3:0]         nib_idx;
    logic [NIB*W-1:0]   out0;
    logic [NIB*W-1:0]   out1;
    logic               busy;
    logic               done;

    modport master (
        output start, dom_s, dom_t,
        input  nib_idx, out0, out1, busy, done
    );

    modport slave (
        input  start, dom_s, dom_t,
        output nib_idx, out0, out1, busy, done
    );

endinterface

// File: rtl/glm_xor16.sv
// Combinational XOR of 16 nibble-wide domain terms into one S-box nibble.
module glm_xor16
    import glm_collect_pkg::*;
(
    input  logic [DOM*W-1:0] terms,
    output logic [W-1:0]     sum
);

    always_comb begin
        // NOTE: a combinational block assigns a default before any
        // conditional or accumulating update so no latch is inferred.
        sum = '0;
        for (int d = 0; d < DOM; d++) begin
            sum = sum ^ terms[d*W +: W];
        end
    end

endmodule

// File: rtl/glm_sbox_collect.sv
// Collects one masked PRINCE S-box layer: registers the GLM domain terms,
// then XOR-compresses each share separately into its nibble of out0/out1.
module glm_sbox_collect
    import glm_collect_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    glm_sbox_collect_if.slave   bus
);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic               v1;
    logic [3:0]         idx1;
    logic [DOM*W-1:0]   s1;
    logic [DOM*W-1:0]   t1;
    logic [W-1:0]       x0;
    logic [W-1:0]       x1;
    logic [NIB*W-1:0]   out0_q;
    logic [NIB*W-1:0]   out1_q;

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.nib_idx = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                bus.busy    = 1'b1;
                bus.nib_idx = cnt;
                if (cnt == 4'(NIB - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.busy  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Glitch barrier: domain terms are registered before any XOR sees them,
    // and the data registers are cleared on reset so no stale share leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            idx1 <= '0;
            s1   <= '0;
            t1   <= '0;
        end else begin
            v1 <= (state == RUN);
            if (state == RUN) begin
                idx1 <= cnt;
                s1   <= bus.dom_s;
                t1   <= bus.dom_t;
            end
        end
    end

    glm_xor16 u_xor_s (.terms(s1), .sum(x0));
    glm_xor16 u_xor_t (.terms(t1), .sum(x1));

    // Each share writes only its own nibble; all others hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q <= '0;
            out1_q <= '0;
        end else if (v1) begin
            out0_q[{idx1, 2'b00} +: W] <= x0;
            out1_q[{idx1, 2'b00} +: W] <= x1;
        end
    end

    assign bus.out0 = out0_q;
    assign bus.out1 = out1_q;

endmodule

// File: doc/glm_sbox_collect.md
GLM_SBOX_COLLECT -- requirements
Module: glm_sbox_collect

Interface
REQ-001 Parameters SHALL be: NIB = 16 (PRINCE state nibbles); DOM = 16 (GLM d1 domains per 4-bit S-box, one per share-index combination of the 4 input bits).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin collecting one full S-box layer; sampled only in IDLE.
REQ-006 dom_s  in  64  share-0 domain terms; domain d at [4d+3:4d], bit k = domain output s_k.
REQ-007 dom_t  in  64  share-1 domain terms; same packing, bit k = t_k.
REQ-008 nib_idx  out  4  nibble index upstream domain logic SHALL evaluate this cycle.
REQ-009 out0  out  64  share-0 S-box layer result; nibble i at [4i+3:4i].
REQ-010 out1  out  64  share-1 S-box layer result; same packing.
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 done  out  1  one-cycle pulse; out0/out1 complete.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN SHALL occur when start=1; cnt SHALL load 0.
REQ-015 In RUN, nib_idx SHALL equal cnt and cnt SHALL increment by 1 per cycle; RUN->DRAIN SHALL occur when cnt=15.
REQ-016 DRAIN->DONE and DONE->IDLE SHALL each take exactly one cycle.
REQ-017 start SHALL be ignored in RUN, DRAIN and DONE, with no effect on cnt, the pipeline or the outputs.
REQ-018 Stage 1 (glitch barrier): each RUN cycle SHALL register all 128 bits of dom_s/dom_t, set v1=1 and set idx1=cnt; v1 SHALL be 0 in every other state.
REQ-019 Stage 1 SHALL be the only logic between dom_s/dom_t and any XOR; no combinational path SHALL exist from dom_* to any output.
REQ-020 Stage 2: when v1=1, out0 nibble idx1 SHALL be written with the XOR of the 16 registered s-nibbles, and out1 nibble idx1 with the XOR of the 16 t-nibbles.
REQ-021 Stage 2 SHALL leave all other nibbles unchanged.
REQ-022 Shares SHALL never be combined: the out0 path SHALL use dom_s only and the out1 path SHALL use dom_t only.
REQ-023 Latency: nibble i SHALL be presented in RUN cycle i and written at the end of RUN cycle i+1, or of the DRAIN cycle for i=15.
REQ-024 done SHALL assert exactly 18 cycles after the cycle in which start is sampled.
REQ-025 out0/out1 SHALL hold their values from done until the next layer overwrites each nibble.
REQ-026 nib_idx SHALL be 0 outside RUN.

Reset
REQ-027 rst SHALL force, at the next edge: state=IDLE, cnt=0, v1=0, idx1=0, stage-1 registers=0, out0=out1=0, busy=0, done=0.
REQ-028 rst SHALL take priority over start and over any state, including mid-RUN; a partially collected layer SHALL be discarded.

Structure
REQ-029 Package glm_collect_pkg SHALL hold the state enum, NIB, DOM and the nibble-slice width constant 4.
REQ-030 Sub-module glm_xor16 SHALL be a combinational 16-nibble XOR reducer, instantiated twice (share 0 and share 1).

Verification
REQ-031 Nibble ordering: dom_s domain 0 = nib_idx, other domains 0; dom_t = 0 -> out0 = 0xFEDCBA9876543210, out1 = 0, done 18 cycles after start.
REQ-032 Share isolation: dom_s all 0xF, dom_t all 0x0 -> out0 = 0 (even count of 0xF cancels), out1 = 0; repeat with domain 3 s-nibble = 0x5 only -> out0 = 0x5555555555555555.
REQ-033 Ignored start: start held high for 30 cycles -> exactly one done per 19-cycle period (IDLE re-entry), busy pattern 17 high / 2 low.
REQ-034 Reset mid-op: rst at RUN cnt=7 -> next cycle IDLE, out0 = out1 = 0, busy = 0, no done pulse.
REQ-035 Hold: after done, change dom_* to random values with no start -> out0/out1 unchanged for 20 cycles.
REQ-036 Masked end-to-end: 16 upstream domain instances driven from a random 2-share split of 0x0123456789ABCDEF -> out0 ^ out1 equals the PRINCE S-box layer of 0x0123456789ABCDEF.
